// File: rtl/axi_master_wr_sched.sv
// Round-robin scheduler sharing one AXI write master among NUM_REQ burst requesters.
// Ports: ACLK/ARESETn, req_* in, gnt/done out, mst_* to master, *_hs from AXI, err_* status.
module axi_master_wr_sched #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_BITS-1:0]    req_len,
  input  logic [NUM_REQ*ID_BITS-1:0]     req_id,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  input  logic                           rd_busy,
  output logic                           mst_write,
  output logic [ADDR_BITS-1:0]           mst_addr,
  output logic [LEN_BITS-1:0]            mst_len,
  output logic [ID_BITS-1:0]             mst_id,
  input  logic                           aw_hs,
  input  logic                           wlast_hs,
  input  logic                           b_hs,
  input  logic [1:0]                     bresp,
  output logic                           err_flag,
  output logic [ID_BITS-1:0]             err_id,
  input  logic                           err_clr
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]        rr_ptr, rr_nx;
  logic [PW-1:0]        own, own_nx;
  logic [NUM_REQ-1:0]   gnt_nx, done_nx;
  logic                 write_nx;
  logic [ADDR_BITS-1:0] addr_nx;
  logic [LEN_BITS-1:0]  len_nx;
  logic [ID_BITS-1:0]   id_nx;
  logic                 eflag_nx;
  logic [ID_BITS-1:0]   eid_nx;

  logic                 found;
  logic [PW-1:0]        win_idx;
  logic [ADDR_BITS-1:0] win_addr;
  logic [LEN_BITS-1:0]  win_len;
  logic [ID_BITS-1:0]   win_id;
  logic                 start;
  logic                 b_done;
  logic                 new_err;

  // Search starts at rr_ptr and wraps, so the last owner goes to the back.
  always_comb begin
    int k;
    k        = 0;
    found    = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    win_len  = '0;
    win_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid[k]) begin
        found    = 1'b1;
        win_idx  = PW'(k);
        win_addr = req_addr[k*ADDR_BITS +: ADDR_BITS];
        win_len  = req_len[k*LEN_BITS +: LEN_BITS];
        win_id   = req_id[k*ID_BITS +: ID_BITS];
      end
    end
  end

  // The read interlock is only consulted while idle.
  assign start   = (state == IDLE) && found && !rd_busy;
  assign b_done  = (state == RESP) && b_hs;
  assign new_err = b_done && (bresp != 2'b00);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start)    state_nx = ISSUE;
      ISSUE: if (aw_hs)    state_nx = DATA;
      DATA:  if (wlast_hs) state_nx = RESP;
      RESP:  if (b_hs)     state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_nx   = gnt;
    done_nx  = '0;
    write_nx = (state_nx == ISSUE);
    own_nx   = own;
    rr_nx    = rr_ptr;
    addr_nx  = mst_addr;
    len_nx   = mst_len;
    id_nx    = mst_id;
    eflag_nx = err_flag;
    eid_nx   = err_id;
    if (start) begin
      gnt_nx          = '0;
      gnt_nx[win_idx] = 1'b1;
      own_nx          = win_idx;
      addr_nx         = win_addr;
      len_nx          = win_len;
      id_nx           = win_id;
    end
    if (b_done) begin
      gnt_nx  = '0;
      done_nx = gnt;
      rr_nx   = (own == PW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
    end
    // A fresh error beats a simultaneous clear; the first error id sticks.
    if (new_err && (!err_flag || err_clr)) begin
      eflag_nx = 1'b1;
      eid_nx   = mst_id;
    end else if (err_clr) begin
      eflag_nx = 1'b0;
      eid_nx   = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      gnt       <= '0;
      done      <= '0;
      mst_write <= 1'b0;
      mst_addr  <= '0;
      mst_len   <= '0;
      mst_id    <= '0;
      err_flag  <= 1'b0;
      err_id    <= '0;
      rr_ptr    <= '0;
      own       <= '0;
    end else begin
      gnt       <= gnt_nx;
      done      <= done_nx;
      mst_write <= write_nx;
      mst_addr  <= addr_nx;
      mst_len   <= len_nx;
      mst_id    <= id_nx;
      err_flag  <= eflag_nx;
      err_id    <= eid_nx;
      rr_ptr    <= rr_nx;
      own       <= own_nx;
    end
  end

endmodule

// File: tb/tb_axi_master_wr_sched.sv
// Self-checking bench for axi_master_wr_sched: directed bursts with an
// expected-grant scoreboard, interlock, error, reset and back-to-back cases.
module tb_axi_master_wr_sched;

  localparam int NR = 2;
  localparam int AB = 32;
  localparam int IB = 4;
  localparam int LB = 4;

  logic           ACLK = 1'b0;
  logic           ARESETn;
  logic [NR-1:0]  req_valid;
  logic [NR*AB-1:0] req_addr;
  logic [NR*LB-1:0] req_len;
  logic [NR*IB-1:0] req_id;
  logic [NR-1:0]  gnt;
  logic [NR-1:0]  done;
  logic           rd_busy;
  logic           mst_write;
  logic [AB-1:0]  mst_addr;
  logic [LB-1:0]  mst_len;
  logic [IB-1:0]  mst_id;
  logic           aw_hs;
  logic           wlast_hs;
  logic           b_hs;
  logic [1:0]     bresp;
  logic           err_flag;
  logic [IB-1:0]  err_id;
  logic           err_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NR-1:0] g;
    logic [AB-1:0] a;
    logic [LB-1:0] l;
    logic [IB-1:0] i;
  } exp_t;

  exp_t exp_q[$];

  axi_master_wr_sched #(
    .NUM_REQ(NR), .ADDR_BITS(AB), .ID_BITS(IB), .LEN_BITS(LB)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_id(req_id),
    .gnt(gnt), .done(done), .rd_busy(rd_busy),
    .mst_write(mst_write), .mst_addr(mst_addr),
    .mst_len(mst_len), .mst_id(mst_id),
    .aw_hs(aw_hs), .wlast_hs(wlast_hs), .b_hs(b_hs),
    .bresp(bresp), .err_flag(err_flag), .err_id(err_id),
    .err_clr(err_clr)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic [AB-1:0] a,
                         input logic [LB-1:0] l, input logic [IB-1:0] i);
    req_addr[n*AB +: AB] = a;
    req_len[n*LB +: LB]  = l;
    req_id[n*IB +: IB]   = i;
  endtask

  task automatic push(input logic [NR-1:0] g, input logic [AB-1:0] a,
                      input logic [LB-1:0] l, input logic [IB-1:0] i);
    exp_t e;
    e.g = g; e.a = a; e.l = l; e.i = i;
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 20 && gnt == '0; i++) step();
    chk("gnt_timeout", 64'(gnt != '0), 64'd1);
  endtask

  task automatic do_burst(input logic [1:0] br, input logic busy_data,
                          input logic clr);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("gnt", 64'(gnt), 64'(e.g));
    chk("issue_write", 64'(mst_write), 64'd1);
    chk("mst_addr", 64'(mst_addr), 64'(e.a));
    chk("mst_len", 64'(mst_len), 64'(e.l));
    chk("mst_id", 64'(mst_id), 64'(e.i));
    aw_hs = 1'b1; step(); aw_hs = 1'b0;
    chk("data_write", 64'(mst_write), 64'd0);
    chk("data_gnt", 64'(gnt), 64'(e.g));
    if (busy_data) rd_busy = 1'b1;
    wlast_hs = 1'b1; step(); wlast_hs = 1'b0;
    b_hs = 1'b1; bresp = br; err_clr = clr;
    step();
    b_hs = 1'b0; bresp = 2'b00; err_clr = 1'b0; rd_busy = 1'b0;
    chk("done", 64'(done), 64'(e.g));
    chk("gnt_free", 64'(gnt), 64'd0);
  endtask

  task automatic chk_reset_state();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_write", 64'(mst_write), 64'd0);
    chk("rst_addr", 64'(mst_addr), 64'd0);
    chk("rst_err", 64'(err_flag), 64'd0);
    chk("rst_err_id", 64'(err_id), 64'd0);
  endtask

  initial begin
    ARESETn = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0; req_id = '0;
    rd_busy = 1'b0; aw_hs = 1'b0; wlast_hs = 1'b0; b_hs = 1'b0;
    bresp = 2'b00; err_clr = 1'b0;
    step(); step();
    ARESETn = 1'b1;
    chk_reset_state();

    // single request, stray handshakes in ISSUE ignored
    set_req(0, 32'h1000, 4'd15, 4'd2);
    req_valid = 2'b01;
    push(2'b01, 32'h1000, 4'd15, 4'd2);
    step();
    chk("t1_latency", 64'(gnt), 64'h1);
    req_valid = '0;
    set_req(0, 32'hdead_beef, 4'd1, 4'd9);
    wlast_hs = 1'b1; step(); wlast_hs = 1'b0;
    chk("t1_wlast_ign", 64'(mst_write), 64'd1);
    b_hs = 1'b1; step(); b_hs = 1'b0;
    chk("t1_b_ign", 64'(mst_write), 64'd1);
    do_burst(2'b00, 1'b0, 1'b0);
    step();
    chk("t1_done_pulse", 64'(done), 64'd0);

    // round-robin from a fresh pointer
    ARESETn = 1'b0; step(); ARESETn = 1'b1;
    chk_reset_state();
    set_req(0, 32'h2000, 4'd3, 4'd1);
    set_req(1, 32'h3000, 4'd7, 4'd4);
    push(2'b01, 32'h2000, 4'd3, 4'd1);
    push(2'b10, 32'h3000, 4'd7, 4'd4);
    push(2'b01, 32'h2000, 4'd3, 4'd1);
    req_valid = 2'b11;
    for (int n = 0; n < 3; n++) begin
      wait_gnt();
      if (n == 2) req_valid = '0;
      do_burst(2'b00, 1'b0, 1'b0);
    end
    step();
    chk("t2_idle", 64'(gnt), 64'd0);

    // read interlock
    rd_busy = 1'b1;
    req_valid = 2'b10;
    set_req(1, 32'h4000, 4'd2, 4'd7);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_blocked", 64'(gnt), 64'd0);
    end
    rd_busy = 1'b0;
    push(2'b10, 32'h4000, 4'd2, 4'd7);
    step();
    chk("t3_release", 64'(gnt), 64'h2);
    req_valid = '0;
    do_burst(2'b00, 1'b1, 1'b0);

    // error capture
    set_req(0, 32'h5000, 4'd0, 4'd3);
    req_valid = 2'b01;
    push(2'b01, 32'h5000, 4'd0, 4'd3);
    wait_gnt(); req_valid = '0;
    do_burst(2'b10, 1'b0, 1'b0);
    chk("t4_flag", 64'(err_flag), 64'd1);
    chk("t4_id", 64'(err_id), 64'd3);
    set_req(0, 32'h5100, 4'd1, 4'd5);
    req_valid = 2'b01;
    push(2'b01, 32'h5100, 4'd1, 4'd5);
    wait_gnt(); req_valid = '0;
    do_burst(2'b10, 1'b0, 1'b0);
    chk("t4_sticky_id", 64'(err_id), 64'd3);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_clr", 64'(err_flag), 64'd0);
    set_req(0, 32'h5200, 4'd2, 4'd6);
    req_valid = 2'b01;
    push(2'b01, 32'h5200, 4'd2, 4'd6);
    wait_gnt(); req_valid = '0;
    do_burst(2'b00, 1'b0, 1'b0);
    chk("t4_clean", 64'(err_flag), 64'd0);
    set_req(0, 32'h5300, 4'd2, 4'd6);
    req_valid = 2'b01;
    push(2'b01, 32'h5300, 4'd2, 4'd6);
    wait_gnt(); req_valid = '0;
    do_burst(2'b11, 1'b0, 1'b1);
    chk("t4_err_wins", 64'(err_flag), 64'd1);
    chk("t4_err_wins_id", 64'(err_id), 64'd6);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // reset mid-burst, pending request restarts at requester 0
    set_req(0, 32'h6000, 4'd4, 4'd8);
    set_req(1, 32'h7000, 4'd5, 4'd9);
    req_valid = 2'b10;
    wait_gnt();
    chk("t5_pre_gnt", 64'(gnt), 64'h2);
    aw_hs = 1'b1; step(); aw_hs = 1'b0;
    req_valid = 2'b11;
    ARESETn = 1'b0; step(); ARESETn = 1'b1;
    chk("t5_gnt", 64'(gnt), 64'd0);
    chk("t5_write", 64'(mst_write), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    push(2'b01, 32'h6000, 4'd4, 4'd8);
    step();
    chk("t5_rearb", 64'(gnt), 64'h1);
    req_valid = '0;
    do_burst(2'b00, 1'b0, 1'b0);

    // back-to-back from one requester
    set_req(0, 32'h8000, 4'd6, 4'd10);
    req_valid = 2'b01;
    push(2'b01, 32'h8000, 4'd6, 4'd10);
    push(2'b01, 32'h8000, 4'd6, 4'd10);
    wait_gnt();
    do_burst(2'b00, 1'b0, 1'b0);
    step();
    chk("t6_regrant", 64'(gnt), 64'h1);
    chk("t6_write", 64'(mst_write), 64'd1);
    chk("t6_done_off", 64'(done), 64'd0);
    req_valid = '0;
    do_burst(2'b00, 1'b0, 1'b0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
